// File: rtl/conv_pkg.sv
// conv_pkg: shared constants, FSM state type and window geometry for the
// 3x3 convolution window sequencer.
//
// Build option: CONV_SAME_PAD_EN selects "same" convolution with zero padding
// (16 windows centred on each pixel). When undefined, "valid" convolution
// is used (2x2 windows, no padding).
package conv_pkg;

   localparam int unsigned IMG_DIM   = 4;
   localparam int unsigned K_DIM     = 3;
   localparam int unsigned TAPS      = K_DIM * K_DIM;
   localparam int unsigned ADDR_W    = 4;
   localparam int unsigned OUT_IDX_W = 4;
   // Width of the window/kernel row and column counters.
   localparam int unsigned CNT_W     = 2;

`ifdef CONV_SAME_PAD_EN
   localparam int unsigned WIN_DIM = IMG_DIM;
   // Tap pixel coordinates are offset by -PAD from window origin + tap offset.
   localparam int unsigned PAD     = 1;
`else
   localparam int unsigned WIN_DIM = IMG_DIM - K_DIM + 1;
   localparam int unsigned PAD     = 0;
`endif

   localparam int unsigned NUM_WIN = WIN_DIM * WIN_DIM;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      FLUSH
   } state_e;

endpackage

// File: rtl/conv_addr_gen.sv
// conv_addr_gen: combinational map from window position and kernel tap to a
// row-major pixel address, with a flag telling whether the tap lands inside
// the image.
//
// Ports:
//   i_wr, i_wc  window row / column
//   i_kr, i_kc  kernel tap row / column
//   o_addr      pixel address (0 when the tap falls outside the image)
//   o_in_range  tap pixel lies inside the IMG_DIM x IMG_DIM image
//
// Build option: CONV_SAME_PAD_EN (via conv_pkg::PAD) shifts taps by -1 so
// windows are centred on their pixel; edge taps then go out of range.
module conv_addr_gen
   import conv_pkg::*;
(
   input  logic [CNT_W-1:0]  i_wr,
   input  logic [CNT_W-1:0]  i_wc,
   input  logic [CNT_W-1:0]  i_kr,
   input  logic [CNT_W-1:0]  i_kc,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_in_range
);

   int w_row;
   int w_col;

   always_comb begin
      w_row      = int'(i_wr) + int'(i_kr) - int'(PAD);
      w_col      = int'(i_wc) + int'(i_kc) - int'(PAD);
      o_in_range = (w_row >= 0) && (w_row < int'(IMG_DIM)) &&
                   (w_col >= 0) && (w_col < int'(IMG_DIM));
      o_addr     = '0;
      if (o_in_range) begin
         o_addr = ADDR_W'(w_row * int'(IMG_DIM) + w_col);
      end
   end

endmodule

// File: rtl/conv_window_sequencer.sv
// conv_window_sequencer: walks a 3x3 kernel over the 4x4 pixel store, one tap
// per cycle, and drives pixel reads plus MAC accumulate/clear controls.
//
// Ports:
//   i_clk, i_rst_n  clock, synchronous active-low reset
//   i_start         frame request, honoured only in IDLE
//   i_abort         synchronous abort, wins over i_start
//   o_addr          pixel address, o_rd_en read strobe, o_tap_idx coefficient
//   o_acc_clr       clear-then-add on first tap of a window (pipelined)
//   o_acc_en        accumulate store data (pipelined one cycle after issue)
//   o_out_valid     accumulator holds a finished window, index on o_out_idx
//   o_busy, o_done  frame activity and end-of-frame pulse
//   o_pad_zero      (CONV_SAME_PAD_EN only) MAC must add zero this cycle
//
// Build option: CONV_SAME_PAD_EN enables "same" convolution with zero padding.
module conv_window_sequencer
   import conv_pkg::*;
(
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_start,
   input  logic                 i_abort,
   output logic [ADDR_W-1:0]    o_addr,
   output logic                 o_rd_en,
   output logic [3:0]           o_tap_idx,
   output logic                 o_acc_clr,
   output logic                 o_acc_en,
   output logic                 o_out_valid,
   output logic [OUT_IDX_W-1:0] o_out_idx,
   output logic                 o_busy,
`ifdef CONV_SAME_PAD_EN
   output logic                 o_done,
   output logic                 o_pad_zero
`else
   output logic                 o_done
`endif
);

   state_e               r_state, w_state_d;
   logic [CNT_W-1:0]     r_wr, r_wc, r_kr, r_kc;
   logic [CNT_W-1:0]     w_wr_d, w_wc_d, w_kr_d, w_kc_d;
   logic                 r_acc_en, r_acc_clr, r_last, r_out_valid;
   logic [OUT_IDX_W-1:0] r_win, r_out_idx;
`ifdef CONV_SAME_PAD_EN
   logic                 r_pad;
`endif

   logic                 w_issue, w_last_tap, w_last_win, w_in_range;
   logic [ADDR_W-1:0]    w_addr;
   logic [3:0]           w_tap;
   logic [OUT_IDX_W-1:0] w_win;

   conv_addr_gen u_addr_gen (
      .i_wr       (r_wr),
      .i_wc       (r_wc),
      .i_kr       (r_kr),
      .i_kc       (r_kc),
      .o_addr     (w_addr),
      .o_in_range (w_in_range)
   );

   always_comb begin
      w_issue    = (r_state == ISSUE);
      w_tap      = 4'(r_kr * K_DIM + r_kc);
      w_win      = OUT_IDX_W'(r_wr * WIN_DIM + r_wc);
      w_last_tap = (r_kr == CNT_W'(K_DIM - 1)) && (r_kc == CNT_W'(K_DIM - 1));
      w_last_win = (r_wr == CNT_W'(WIN_DIM - 1)) && (r_wc == CNT_W'(WIN_DIM - 1));
   end

   // Nested row-major counters: kc fastest, then kr, wc, wr. All wrap back
   // to 0 after the final tap, so IDLE always restarts from window 0.
   always_comb begin
      w_wr_d = r_wr;
      w_wc_d = r_wc;
      w_kr_d = r_kr;
      w_kc_d = r_kc;
      if (w_issue) begin
         if (r_kc == CNT_W'(K_DIM - 1)) begin
            w_kc_d = '0;
            if (r_kr == CNT_W'(K_DIM - 1)) begin
               w_kr_d = '0;
               if (r_wc == CNT_W'(WIN_DIM - 1)) begin
                  w_wc_d = '0;
                  w_wr_d = (r_wr == CNT_W'(WIN_DIM - 1)) ? '0 : r_wr + 1'b1;
               end else begin
                  w_wc_d = r_wc + 1'b1;
               end
            end else begin
               w_kr_d = r_kr + 1'b1;
            end
         end else begin
            w_kc_d = r_kc + 1'b1;
         end
      end
   end

   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         IDLE:    if (i_start) w_state_d = ISSUE;
         ISSUE:   if (w_last_tap && w_last_win) w_state_d = DRAIN;
         DRAIN:   w_state_d = FLUSH;
         FLUSH:   w_state_d = IDLE;
         default: w_state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_abort) begin
         r_state     <= IDLE;
         r_wr        <= '0;
         r_wc        <= '0;
         r_kr        <= '0;
         r_kc        <= '0;
         r_acc_en    <= 1'b0;
         r_acc_clr   <= 1'b0;
         r_last      <= 1'b0;
         r_win       <= '0;
         r_out_valid <= 1'b0;
         r_out_idx   <= '0;
`ifdef CONV_SAME_PAD_EN
         r_pad       <= 1'b0;
`endif
      end else begin
         r_state     <= w_state_d;
         r_wr        <= w_wr_d;
         r_wc        <= w_wc_d;
         r_kr        <= w_kr_d;
         r_kc        <= w_kc_d;
         // Padded taps still accumulate (a zero), so acc_en follows issue,
         // not rd_en.
         r_acc_en    <= w_issue;
         r_acc_clr   <= w_issue && (w_tap == 4'd0);
         r_last      <= w_issue && w_last_tap;
         r_win       <= w_win;
         // Result is ready the cycle after the last tap's accumulate.
         r_out_valid <= r_last;
         r_out_idx   <= r_last ? r_win : '0;
`ifdef CONV_SAME_PAD_EN
         r_pad       <= w_issue && !w_in_range;
`endif
      end
   end

   always_comb begin
      o_rd_en     = w_issue && w_in_range;
      o_addr      = w_issue ? w_addr : '0;
      o_tap_idx   = w_issue ? w_tap : '0;
      o_acc_en    = r_acc_en;
      o_acc_clr   = r_acc_clr;
      o_out_valid = r_out_valid;
      o_out_idx   = r_out_idx;
      o_busy      = (r_state != IDLE);
      o_done      = (r_state == FLUSH);
`ifdef CONV_SAME_PAD_EN
      o_pad_zero  = r_pad;
`endif
   end

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Self-checking bench for conv_window_sequencer: a frame-schedule model
// predicts every output from the cycle offset within the current frame,
// plus directed frames with hand-computed literal expectations.
module tb_conv_window_sequencer;

`ifdef CONV_SAME_PAD_EN
   localparam int WD = 4;
   localparam int PD = 1;
`else
   localparam int WD = 2;
   localparam int PD = 0;
`endif
   localparam int NW   = WD * WD;
   localparam int FLEN = 9 * NW + 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [3:0] addr, tap_idx, out_idx;
   logic       rd_en, acc_clr, acc_en, out_valid, busy, done, pad_zero;

   int n_tests = 0;
   int n_fail  = 0;
   int m_t     = 0;   // cycle offset within the current frame, 0 = idle
   bit chk_en  = 1'b0;

   conv_window_sequencer dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_start     (start),
      .i_abort     (abort),
      .o_addr      (addr),
      .o_rd_en     (rd_en),
      .o_tap_idx   (tap_idx),
      .o_acc_clr   (acc_clr),
      .o_acc_en    (acc_en),
      .o_out_valid (out_valid),
      .o_out_idx   (out_idx),
      .o_busy      (busy),
`ifdef CONV_SAME_PAD_EN
      .o_done      (done),
      .o_pad_zero  (pad_zero)
`else
      .o_done      (done)
`endif
   );

`ifndef CONV_SAME_PAD_EN
   assign pad_zero = 1'b0;
`endif

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input int exp);
      n_tests++;
      if (act !== 32'(exp)) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Tap pixel for window w, tap k; inr=0 when it falls outside the image.
   function automatic void pix(input int w, input int k, output int a, output bit inr);
      int r;
      int c;
      r   = w / WD + k / 3 - PD;
      c   = w % WD + k % 3 - PD;
      inr = (r >= 0) && (r < 4) && (c >= 0) && (c < 4);
      a   = inr ? r * 4 + c : 0;
   endfunction

   // Frame schedule: start accepted only when idle; abort/reset end a frame.
   always @(posedge clk) begin
      if (!rst_n || abort)   m_t <= 0;
      else if (m_t == 0)     m_t <= start ? 1 : 0;
      else if (m_t == FLEN)  m_t <= 0;
      else                   m_t <= m_t + 1;
   end

   always @(negedge clk) begin
      int e_addr, e_tap, e_oidx, a, j;
      bit e_rd, e_en, e_clr, e_pad, e_ov, inr;
      if (chk_en) begin
         e_addr = 0; e_tap = 0; e_oidx = 0;
         e_rd = 0; e_en = 0; e_clr = 0; e_pad = 0; e_ov = 0;
         if (m_t >= 1 && m_t <= 9 * NW) begin
            j = m_t - 1;
            pix(j / 9, j % 9, a, inr);
            e_rd = inr; e_addr = a; e_tap = j % 9;
         end
         if (m_t >= 2 && m_t <= 9 * NW + 1) begin
            j = m_t - 2;
            pix(j / 9, j % 9, a, inr);
            e_en = 1; e_clr = (j % 9 == 0); e_pad = !inr;
         end
         if (m_t >= 11 && (m_t - 11) % 9 == 0) begin
            e_ov = 1; e_oidx = (m_t - 11) / 9;
         end
         chk("addr", addr, e_addr);
         chk("rd_en", rd_en, e_rd);
         chk("tap_idx", tap_idx, e_tap);
         chk("acc_en", acc_en, e_en);
         chk("acc_clr", acc_clr, e_clr);
         chk("out_valid", out_valid, e_ov);
         chk("out_idx", out_idx, e_oidx);
         chk("busy", busy, m_t >= 1);
         chk("done", done, m_t == FLEN);
`ifdef CONV_SAME_PAD_EN
         chk("pad_zero", pad_zero, e_pad);
`endif
      end
   end

   // Hand-computed expectations for window 0 (cycles 1..9).
`ifdef CONV_SAME_PAD_EN
   int lit_w0_addr [9] = '{0, 0, 0, 0, 0, 1, 0, 4, 5};
   int lit_w0_rd   [9] = '{0, 0, 0, 0, 1, 1, 0, 1, 1};
   int lit_w0_pad  [9] = '{1, 1, 1, 1, 0, 0, 1, 0, 0};
`else
   int lit_w0_addr [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
   int lit_w0_rd   [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
   int lit_w1_addr [9] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
   int lit_w3_addr [9] = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
`endif

   task automatic frame_literal();
      int oc = 0;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int c = 1; c <= FLEN; c++) begin
         @(negedge clk);
         if (c <= 9) begin
            chk("lit_w0_addr", addr, lit_w0_addr[c-1]);
            chk("lit_w0_rd", rd_en, lit_w0_rd[c-1]);
            chk("lit_w0_tap", tap_idx, c - 1);
         end
`ifdef CONV_SAME_PAD_EN
         if (c >= 2 && c <= 10) chk("lit_w0_pad", pad_zero, lit_w0_pad[c-2]);
`else
         if (c >= 10 && c <= 18) chk("lit_w1_addr", addr, lit_w1_addr[c-10]);
         if (c >= 28 && c <= 36) chk("lit_w3_addr", addr, lit_w3_addr[c-28]);
         if (c == 37) chk("lit_rd_c37", rd_en, 0);
         if (c == 37) chk("lit_en_c37", acc_en, 1);
`endif
         if (c == 1) chk("lit_en_c1", acc_en, 0);
         if (c == 2) begin
            chk("lit_clr_c2", acc_clr, 1);
            chk("lit_en_c2", acc_en, 1);
         end
         chk("lit_done", done, (c == FLEN) ? 1 : 0);
         chk("lit_busy", busy, 1);
         if (out_valid === 1'b1) begin
            chk("lit_ov_cycle", c, 11 + 9 * oc);
            chk("lit_ov_idx", out_idx, oc);
            oc++;
         end
      end
      chk("lit_ov_count", oc, NW);
      @(negedge clk);
      chk("lit_idle_busy", busy, 0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk_en = 1'b1;
      @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_addr", addr, 0);

      frame_literal();

      // start held high: exactly one frame, next one issues at cycle FLEN+2.
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= FLEN + 2; c++) begin
         @(negedge clk);
         if (c == FLEN + 1) chk("hold_idle_rd", rd_en, 0);
         if (c == FLEN + 1) chk("hold_idle_busy", busy, 0);
         if (c == FLEN + 2) chk("hold_restart_rd", rd_en, lit_w0_rd[0]);
         if (c == FLEN + 2) chk("hold_restart_busy", busy, 1);
      end
      start = 1'b0;
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;

      // Abort at cycle 15.
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (15) @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      @(negedge clk);
      chk("abort_busy", busy, 0);
      chk("abort_acc_en", acc_en, 0);
      chk("abort_rd_en", rd_en, 0);
      for (int c = 17; c <= FLEN + 5; c++) begin
         @(negedge clk);
         chk("abort_no_done", done, 0);
         chk("abort_no_ov", out_valid, 0);
      end
      frame_literal();

      // Reset pulse at cycle 20.
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_acc_en", acc_en, 0);
      for (int c = 22; c <= FLEN + 5; c++) begin
         @(negedge clk);
         chk("rst_no_done", done, 0);
      end
      frame_literal();

      // Randomized traffic against the schedule model.
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #1;
         start = ($urandom_range(0, 3) == 0);
         abort = ($urandom_range(0, 199) == 0);
         rst_n = ($urandom_range(0, 299) != 0);
      end
      #1;
      start = 1'b0;
      abort = 1'b0;
      rst_n = 1'b1;
      repeat (FLEN + 5) @(posedge clk);
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/conv_window_sequencer.md
Name: conv_window_sequencer

Overview:
Sequences a 3x3 convolution kernel over the 4x4 4-bit image held in the row-addressed pixel store. It emits one pixel address per cycle to the 4-bit row-select decoder, with matching kernel tap index and accumulator controls. It sits between the top-level start/done handshake and the pixel-store/MAC datapath. Default mode is "valid" convolution: 2x2 outputs, 4 windows x 9 taps.

Parameters:
IMG_DIM, 4, image side length in pixels
K_DIM, 3, kernel side length
ADDR_W, 4, pixel address width (log2 of IMG_DIM*IMG_DIM)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
start  in  1  frame request; sampled only in IDLE
abort  in  1  synchronous abort; priority over start
addr  out  ADDR_W  pixel address to row-select decoder
rd_en  out  1  pixel read strobe; store returns data next cycle
tap_idx  out  4  kernel coefficient index 0..8, aligned with addr
acc_clr  out  1  clear accumulator before adding the current tap (first tap of window)
acc_en  out  1  accumulate store data with coefficient (rd_en delayed 1 cycle)
out_valid  out  1  accumulator holds a finished window result
out_idx  out  4  output pixel index, row-major; upper bits 0 in valid mode
busy  out  1  high from first issue cycle through the done cycle
done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE. All outputs 0, counters 0, pipeline register cleared.
- States: IDLE -> ISSUE -> DRAIN -> FLUSH -> IDLE.
- IDLE: start=1 and abort=0 -> ISSUE next cycle. Call that start edge cycle 0.
- ISSUE:
  - One tap per cycle, no bubbles between windows.
  - Window order is row-major (wr, wc). Tap order is row-major (kr, kc).
  - Outputs: tap_idx = kr*3+kc; addr = (wr+kr)*IMG_DIM + (wc+kc); rd_en=1.
  - After tap 8 of the last window -> DRAIN.
- Pipeline stage (1 cycle): acc_en and acc_clr are registered copies of rd_en and (tap_idx==0) from the previous cycle.
- out_valid pulses the cycle after the acc_en of tap 8, with out_idx = window index.
- DRAIN: rd_en=0; last acc_en issues. Next state FLUSH.
- FLUSH: final out_valid; done=1; busy=1. Next state IDLE.
- Valid-mode timing:
  - rd_en high cycles 1..36; acc_en high cycles 2..37.
  - out_valid at cycles 11, 20, 29, 38; done at cycle 38; busy high cycles 1..38.
- start while busy: ignored, no queuing. start in the same cycle as done: ignored, because state is not IDLE.
- abort=1 in any state: next cycle IDLE, all outputs 0, pipeline cleared, no done. A result may already have been partly accumulated; it is discarded.
- rst_n low mid-frame behaves the same as abort.
- addr is always in range 0..15 in valid mode, so no wrap-around.

Optional Feature:
CONV_SAME_PAD_EN
- Defined: "same" convolution with zero padding.
  - 16 windows, each centred on a pixel (wr, wc in 0..3); tap pixel is (wr+kr-1, wc+kc-1).
  - Out-of-range taps still consume a cycle and still drive tap_idx. For those taps: rd_en=0, addr=0. The pipelined acc_en stays 1 and a pad_zero output is asserted with it, so the MAC adds 0.
  - out_idx spans 0..15; out_valid at cycle 11+9k for k=0..15; done at cycle 146.
- Undefined: pad_zero port absent; behaviour as above.

Decomposition:
- Package conv_pkg holds:
  - constants IMG_DIM, K_DIM, TAPS=9, ADDR_W, OUT_IDX_W=4;
  - the state enum {IDLE, ISSUE, DRAIN, FLUSH};
  - the window-count constant selected by CONV_SAME_PAD_EN.
- One sub-module, conv_addr_gen: combinational mapping (wr, wc, kr, kc) -> addr, in-range flag. The sequencer owns all counters and the FSM.

Test Plan:
- Reset then start pulse at cycle 0:
  - window 0 addr sequence 0,1,2,4,5,6,8,9,10 on cycles 1..9;
  - tap_idx 0..8; acc_clr with acc_en at cycle 2.
- Full frame:
  - window 1 addrs 1,2,3,5,6,7,9,10,11;
  - window 3 addrs 5,6,7,9,10,11,13,14,15;
  - out_valid at 11/20/29/38 with out_idx 0..3; done=1 only at cycle 38.
- start held high throughout the frame: single frame only. A new frame begins only if start=1 at cycle 39 (state IDLE); next rd_en at cycle 40.
- abort at cycle 15: cycle 16 all outputs 0, state IDLE, no further out_valid, done never asserted. A fresh start afterwards reproduces the cycle-1 addr 0.
- rst_n=0 at cycle 20 for one cycle: same as the abort case; busy=0 the next cycle.
- CONV_SAME_PAD_EN, window 0:
  - taps 0,1,2,3,6 give rd_en=0 and pad_zero=1;
  - taps 4,5,7,8 give addr 0,1,4,5;
  - done at cycle 146.
